// File: rtl/tweak_serpar_ctrl_if.sv
// Handshake and strobe bundle between the tweakey serial/parallel buffer
// controller and its surroundings (input interface, core, mode logic, top FSM).
interface tweak_serpar_ctrl_if #(
  parameter int CNT_W = 6
);
  logic             load_start;
  logic             pdi_valid;
  logic             pdi_ready;
  logic             run_start;
  logic             rnd_step;
  logic             crct_req;
  logic             abort;
  logic             wr;
  logic             en;
  logic             crct;
  logic             key_valid;
  logic             busy;
  logic             rounds_done;
  logic [CNT_W-1:0] rnd_cnt;

  modport master (
    output load_start, pdi_valid, run_start, rnd_step, crct_req, abort,
    input  pdi_ready, wr, en, crct, key_valid, busy, rounds_done, rnd_cnt
  );

  modport slave (
    input  load_start, pdi_valid, run_start, rnd_step, crct_req, abort,
    output pdi_ready, wr, en, crct, key_valid, busy, rounds_done, rnd_cnt
  );
endinterface

// File: rtl/tweak_serpar_ctrl.sv
// Sequencer for the 128-bit tweakey serial/parallel buffer: word loading,
// per-round core loads, corrected-key loads and round counting.
module tweak_serpar_ctrl #(
  parameter int NUM_WORDS = 4,
  parameter int ROUNDS    = 40,
  parameter int CNT_W     = 6
) (
  input  logic                clk,
  input  logic                rst,
  tweak_serpar_ctrl_if.slave  bus
);
  localparam int WC_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, READY, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WC_W-1:0]    word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]   rnd_cnt_q, rnd_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      rnd_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      rnd_cnt_q  <= rnd_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    rnd_cnt_d  = rnd_cnt_q;
    if (bus.abort) begin
      state_d    = IDLE;
      word_cnt_d = '0;
      rnd_cnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.load_start) begin
          state_d    = LOAD;
          word_cnt_d = '0;
          rnd_cnt_d  = '0;
        end
        LOAD: begin
          // a restart wins over a word arriving in the same cycle
          if (bus.load_start) begin
            word_cnt_d = '0;
          end else if (bus.pdi_valid) begin
            if (word_cnt_q == WC_W'(NUM_WORDS - 1)) begin
              state_d    = READY;
              word_cnt_d = '0;
            end else begin
              word_cnt_d = word_cnt_q + WC_W'(1);
            end
          end
        end
        READY: begin
          if (bus.load_start) begin
            state_d    = LOAD;
            word_cnt_d = '0;
            rnd_cnt_d  = '0;
          end else if (!bus.crct_req && bus.run_start) begin
            state_d   = RUN;
            rnd_cnt_d = '0;
          end
        end
        RUN: if (bus.rnd_step) begin
          if (rnd_cnt_q == CNT_W'(ROUNDS - 1)) state_d = DONE;
          else                                 rnd_cnt_d = rnd_cnt_q + CNT_W'(1);
        end
        DONE: begin
          if (bus.load_start) begin
            state_d    = LOAD;
            word_cnt_d = '0;
            rnd_cnt_d  = '0;
          end else if (bus.crct_req) begin
            state_d   = READY;
            rnd_cnt_d = '0;
          end else if (bus.run_start) begin
            state_d   = RUN;
            rnd_cnt_d = '0;
          end
        end
        default: begin
          state_d    = IDLE;
          word_cnt_d = '0;
          rnd_cnt_d  = '0;
        end
      endcase
    end
  end

  // Mealy strobes so each one lines up with the data it loads; forced low under rst
  always_comb begin
    bus.wr          = 1'b0;
    bus.en          = 1'b0;
    bus.crct        = 1'b0;
    bus.pdi_ready   = 1'b0;
    bus.key_valid   = 1'b0;
    bus.busy        = 1'b0;
    bus.rounds_done = 1'b0;
    bus.rnd_cnt     = '0;
    if (!rst) begin
      bus.pdi_ready   = (state_q == LOAD);
      bus.busy        = (state_q == LOAD) || (state_q == RUN);
      bus.key_valid   = (state_q == READY) || (state_q == RUN) || (state_q == DONE);
      bus.rounds_done = (state_q == DONE);
      bus.rnd_cnt     = rnd_cnt_q;
      if (!bus.abort) begin
        bus.wr   = (state_q == LOAD) && bus.pdi_valid;
        bus.en   = (state_q == RUN) && bus.rnd_step;
        bus.crct = ((state_q == READY) || (state_q == DONE)) && bus.crct_req && !bus.load_start;
      end
    end
  end
endmodule

// File: tb/tb_tweak_serpar_ctrl.sv
// Directed test-plan sequences followed by random traffic, all checked
// cycle by cycle against a behavioural model of the controller.
module tb_tweak_serpar_ctrl;
  localparam int NW = 4, R = 40, CW = 6;
  localparam int S_IDLE = 0, S_LOAD = 1, S_READY = 2, S_RUN = 3, S_DONE = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tweak_serpar_ctrl_if #(.CNT_W(CW)) bus();
  tweak_serpar_ctrl #(.NUM_WORDS(NW), .ROUNDS(R), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0, n_err = 0;
  int m_st = S_IDLE, m_wc = 0, m_rc = 0;
  int n_wr = 0, n_en = 0, n_crct = 0;
  int base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drv(input bit ls, pv, rn, rs, cq, ab);
    bus.load_start = ls; bus.pdi_valid = pv; bus.run_start = rn;
    bus.rnd_step = rs; bus.crct_req = cq; bus.abort = ab;
  endtask

  // Check outputs mid-cycle, then advance the model across the edge.
  task automatic cyc();
    bit ls, pv, rn, rs, cq, ab, live;
    #2;
    ls = bus.load_start; pv = bus.pdi_valid; rn = bus.run_start;
    rs = bus.rnd_step;   cq = bus.crct_req;  ab = bus.abort;
    live = !rst;
    chk("wr",    bus.wr,   32'(live && !ab && m_st == S_LOAD && pv));
    chk("en",    bus.en,   32'(live && !ab && m_st == S_RUN && rs));
    chk("crct",  bus.crct, 32'(live && !ab && (m_st == S_READY || m_st == S_DONE) && cq && !ls));
    chk("pdi_ready",   bus.pdi_ready,   32'(live && m_st == S_LOAD));
    chk("key_valid",   bus.key_valid,   32'(live && m_st >= S_READY));
    chk("busy",        bus.busy,        32'(live && (m_st == S_LOAD || m_st == S_RUN)));
    chk("rounds_done", bus.rounds_done, 32'(live && m_st == S_DONE));
    chk("rnd_cnt",     32'(bus.rnd_cnt), live ? 32'(m_rc) : 32'd0);
    chk("word_cnt",    32'(dut.word_cnt_q), 32'(m_wc));
    chk("excl", 32'($countones({bus.wr, bus.en, bus.crct}) <= 1), 32'd1);
    n_wr += int'(bus.wr); n_en += int'(bus.en); n_crct += int'(bus.crct);

    if (rst || ab) begin
      m_st = S_IDLE; m_wc = 0; m_rc = 0;
    end else if (ls && m_st != S_RUN) begin
      if (m_st != S_LOAD) m_rc = 0;
      m_st = S_LOAD; m_wc = 0;
    end else begin
      case (m_st)
        S_LOAD:  if (pv) begin
                   m_wc++;
                   if (m_wc == NW) begin m_st = S_READY; m_wc = 0; end
                 end
        S_READY: if (!cq && rn) begin m_st = S_RUN; m_rc = 0; end
        S_RUN:   if (rs) begin
                   if (m_rc == R - 1) m_st = S_DONE;
                   else m_rc++;
                 end
        S_DONE:  if (cq) begin m_st = S_READY; m_rc = 0; end
                 else if (rn) begin m_st = S_RUN; m_rc = 0; end
        default: ;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drv(0, 0, 0, 0, 0, 0);
    repeat (n) cyc();
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    cyc(); cyc();
    rst = 1'b0;

    // 1: plain four-word load
    base = n_wr;
    drv(1, 0, 0, 0, 0, 0); cyc();
    repeat (NW) begin drv(0, 1, 0, 0, 0, 0); cyc(); end
    idle(1);
    chk("t1_wr_pulses", 32'(n_wr - base), 32'd4);
    chk("t1_key_valid", 32'(bus.key_valid), 32'd1);

    // 2: load with gaps
    begin
      bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
      base = n_wr;
      drv(1, 0, 0, 0, 0, 0); cyc();
      foreach (pat[i]) begin drv(0, pat[i], 0, 0, 0, 0); cyc(); end
      idle(1);
      chk("t2_wr_pulses", 32'(n_wr - base), 32'd4);
    end

    // 3: full round sequence with spaced steps
    base = n_en;
    drv(0, 0, 1, 0, 0, 0); cyc();
    repeat (R) begin
      drv(0, 0, 0, 1, 0, 0); cyc();
      idle($urandom_range(0, 2));
    end
    chk("t3_en_pulses", 32'(n_en - base), 32'(R));
    chk("t3_done", 32'(bus.rounds_done), 32'd1);
    drv(0, 0, 0, 1, 0, 0); cyc();
    chk("t3_extra_step", 32'(n_en - base), 32'(R));

    // 4: crct wins over run_start in DONE, then repeated requests in READY
    base = n_crct;
    drv(0, 0, 1, 0, 1, 0); cyc();
    drv(0, 0, 0, 0, 1, 0); cyc(); cyc();
    idle(1);
    chk("t4_crct_pulses", 32'(n_crct - base), 32'd3);

    // 5: load_start ignored mid-run, abort mid-run
    drv(0, 0, 1, 0, 0, 0); cyc();
    repeat (17) begin drv(0, 0, 0, 1, 0, 0); cyc(); end
    base = n_wr;
    drv(1, 1, 0, 1, 0, 0); cyc();
    chk("t5_no_wr", 32'(n_wr - base), 32'd0);
    repeat (2) begin drv(0, 0, 0, 1, 0, 0); cyc(); end
    base = n_en;
    drv(0, 0, 0, 1, 1, 1); cyc();
    chk("t5_abort_no_en", 32'(n_en - base), 32'd0);
    idle(1);
    chk("t5_kv_after_abort", 32'(bus.key_valid), 32'd0);

    // 6: reset mid-load, then a clean load
    drv(1, 0, 0, 0, 0, 0); cyc();
    repeat (2) begin drv(0, 1, 0, 0, 0, 0); cyc(); end
    drv(0, 1, 0, 0, 0, 0); rst = 1'b1; cyc(); rst = 1'b0;
    drv(1, 0, 0, 0, 0, 0); cyc();
    repeat (NW) begin drv(0, 1, 0, 0, 0, 0); cyc(); end
    idle(1);
    chk("t6_key_valid", 32'(bus.key_valid), 32'd1);

    // random traffic
    repeat (4000) begin
      drv($urandom_range(0, 99) < 4, $urandom_range(0, 1) == 1,
          $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 50,
          $urandom_range(0, 99) < 10, $urandom_range(0, 299) == 0);
      rst = ($urandom_range(0, 499) == 0);
      cyc();
    end
    rst = 1'b0;
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tweak_serpar_ctrl.md
Name: tweak_serpar_ctrl

Overview:
- Sequencing controller for the 128-bit tweakey serial-to-parallel buffer in the DOM1 Romulus-N datapath.
- Generates the buffer's mutually exclusive `wr` (shift in a 32-bit pdi word), `en` (load the round key from the core) and `crct` (load the corrected key from the mode logic) strobes.
- Runs the word-load handshake with the input interface, counts SKINNY rounds, and reports key-ready and rounds-done status to the top-level FSM.

Parameters:
- NUM_WORDS, 4, number of 32-bit pdi words forming one 128-bit tweakey share.
- ROUNDS, 40, SKINNY-128-384+ rounds per block; one `en` strobe per round.
- CNT_W, 6, round counter width; must satisfy 2^CNT_W >= ROUNDS.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset; synchronous, active-high.
- load_start  input  1  pulse: begin loading a new tweakey.
- pdi_valid  input  1  pdi word present on the buffer's pdi bus.
- pdi_ready  output  1  controller accepts a pdi word this cycle.
- run_start  input  1  pulse: begin a block's round sequence.
- rnd_step  input  1  core finished a round; the next round key is on data_core.
- crct_req  input  1  mode logic requests loading the corrected key (data_mode).
- abort  input  1  drop the current operation and return to IDLE.
- wr  output  1  buffer shift-load strobe.
- en  output  1  buffer core-load strobe.
- crct  output  1  buffer mode-load strobe.
- key_valid  output  1  buffer holds a complete, usable key.
- busy  output  1  state is LOAD or RUN.
- rounds_done  output  1  all ROUNDS round keys have been consumed.
- rnd_cnt  output  CNT_W  current round index.

Behaviour:
- States: IDLE, LOAD, READY, RUN, DONE.
- Registered state: state, word_cnt (clog2(NUM_WORDS) bits) and rnd_cnt.
- Strobes and pdi_ready are combinational decodes of state and inputs (Mealy, zero latency), so the strobe coincides with its data:
  - wr = LOAD & pdi_valid
  - en = RUN & rnd_step
  - crct = (READY | DONE) & crct_req & ~load_start & ~abort
- At most one of wr, en and crct is high in any cycle, by construction.
- Reset (rst=1 at a clock edge): state=IDLE, word_cnt=0, rnd_cnt=0.
  - All outputs read 0, including while rst is held.
  - rst takes effect mid-LOAD or mid-RUN; the partial buffer content is abandoned and key_valid=0.
- abort: same effect as rst, except it is an input and not a reset. It has priority over every other input in every state, and all strobes are 0 in the abort cycle.
- IDLE:
  - load_start -> LOAD with word_cnt=0.
  - run_start, rnd_step and crct_req are ignored.
- LOAD:
  - pdi_ready=1.
  - Each cycle with pdi_valid increments word_cnt.
  - pdi_valid with word_cnt==NUM_WORDS-1 -> READY, word_cnt=0.
  - Gaps (pdi_valid=0) hold state. load_start in LOAD restarts word_cnt at 0.
- READY:
  - key_valid=1. Input priority: load_start > crct_req > run_start.
  - load_start -> LOAD; key_valid drops the next cycle.
  - crct_req -> crct=1 for that cycle; stay in READY.
  - run_start -> RUN, rnd_cnt=0.
- RUN:
  - busy=1, key_valid=1.
  - Each rnd_step asserts en and increments rnd_cnt.
  - rnd_step with rnd_cnt==ROUNDS-1 -> DONE, with rnd_cnt held at ROUNDS-1 (no wrap).
  - run_start, crct_req and load_start are ignored in RUN; only abort or rst exits early.
- DONE:
  - rounds_done=1, key_valid=1.
  - load_start -> LOAD.
  - crct_req -> crct=1, then READY with rnd_cnt=0.
  - run_start -> RUN with rnd_cnt=0, with no crct (next block reuses the core-evolved key).
  - Priority: load_start > crct_req > run_start.
- rnd_step outside RUN produces no strobe and no count change.

Test Plan:
1. rst, then load_start, then 4 consecutive pdi_valid cycles -> wr high exactly 4 cycles coincident with pdi_valid; key_valid=1 from the cycle after the 4th word; busy=0.
2. Load with pdi_valid pattern 1,0,0,1,1,0,1 -> exactly 4 wr pulses; READY is entered after the 7th cycle; word_cnt never exceeds 3.
3. READY, run_start, then 40 rnd_step pulses spaced 1–3 cycles apart -> 40 en pulses; rnd_cnt counts 0..39; rounds_done=1 after the 40th; an extra rnd_step produces no en.
4. DONE with crct_req and run_start high in the same cycle -> crct=1 and en=0; next state READY with rnd_cnt=0; crct_req in READY gives a single crct pulse per request cycle.
5. load_start during RUN at round 17 -> ignored (no wr, rnd_cnt continues); abort at round 20 -> next cycle IDLE, key_valid=0, rnd_cnt=0, no strobe in the abort cycle.
6. rst asserted after the 2nd load word -> IDLE, all outputs 0; a new load_start plus 4 words completes normally.
